hps_clkgen_multi: RTL and testbench

- Multi-channel programmable clock generator. It is the synthesizable, parametrised successor to the fixed single-output PLL wrapper.
- Runs from the 100 MHz fabric clock and produces NUM_CH divided clocks for the logic-analyzer sampling paths. Each divided clock has a runtime-programmable period, high time and phase offset, plus a one-cycle rising-edge strobe.
- Adds runtime reconfiguration, per-channel enable, a global phase resync and a `locked` indication that follows reconfiguration. The fixed PLL wrapper has none of these.

---
 rtl/hps_clkgen_pkg.sv | 39 +++
 rtl/hps_clkgen_ch.sv | 76 +++++++
 rtl/hps_clkgen_multi.sv | 91 +++++++++
 tb/tb_hps_clkgen_multi.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_clkgen_pkg.sv
// Shared types and configuration clamping for the multi-channel clock generator.
// cfg_t fixes the counter width; the top-level CNT_W must equal CFG_CNT_W.
package hps_clkgen_pkg;

  localparam int CFG_CNT_W = 16;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } ch_state_t;

  typedef struct packed {
    logic                 en;
    logic [CFG_CNT_W-1:0] div;
    logic [CFG_CNT_W-1:0] high;
    logic [CFG_CNT_W-1:0] phase;
  } cfg_t;

  localparam logic [CFG_CNT_W-1:0] CNT_ONE = CFG_CNT_W'(1);
  localparam logic [CFG_CNT_W-1:0] CNT_TWO = CFG_CNT_W'(2);

  localparam cfg_t CFG_RST = '{en: 1'b0, div: CNT_TWO, high: CNT_ONE, phase: '0};

  // Period of at least 2, and at least one low cycle and one high cycle per period.
  function automatic cfg_t clamp_cfg(input logic                 en,
                                     input logic [CFG_CNT_W-1:0] div,
                                     input logic [CFG_CNT_W-1:0] high,
                                     input logic [CFG_CNT_W-1:0] phase);
    cfg_t c;
    c.en    = en;
    c.div   = (div < CNT_TWO) ? CNT_TWO : div;
    c.high  = (high == '0) ? CNT_ONE : high;
    if (c.high >= c.div) c.high = c.div - CNT_ONE;
    c.phase = phase;
    return c;
  endfunction

endpackage

// File: rtl/hps_clkgen_ch.sv
// One divided-clock channel: OFF/ALIGN/RUN state machine with phase and period counters.
// Outputs are registered from the next-state values so they track the state entered.
module hps_clkgen_ch
  import hps_clkgen_pkg::*;
(
  input  logic refclk,
  input  logic rst_n,
  input  logic load_i,
  input  cfg_t load_cfg_i,
  input  logic resync_i,
  output logic outclk_o,
  output logic stb_o,
  output logic align_o
);

  cfg_t                 cfg_q, cfg_d;
  ch_state_t            state_q, state_d;
  logic [CFG_CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_CNT_W-1:0] pcnt_q, pcnt_d;
  logic                 outclk_q, outclk_d;
  logic                 stb_q, stb_d;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      cfg_q    <= CFG_RST;
      state_q  <= OFF;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      outclk_q <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      outclk_q <= outclk_d;
      stb_q    <= stb_d;
    end
  end

  always_comb begin
    cfg_d   = cfg_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    // A write always wins over resync so the channel restarts with its new values.
    if (load_i) begin
      cfg_d   = load_cfg_i;
      state_d = load_cfg_i.en ? ALIGN : OFF;
      pcnt_d  = load_cfg_i.phase;
    end else if (resync_i && cfg_q.en) begin
      state_d = ALIGN;
      pcnt_d  = cfg_q.phase;
    end else begin
      case (state_q)
        ALIGN: begin
          if (pcnt_q == '0) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            pcnt_d = pcnt_q - CNT_ONE;
          end
        end
        RUN:     cnt_d = (cnt_q == cfg_q.div - CNT_ONE) ? '0 : cnt_q + CNT_ONE;
        default: ;
      endcase
    end
    outclk_d = (state_d == RUN) && (cnt_d < cfg_d.high);
    stb_d    = (state_d == RUN) && (cnt_d == '0);
  end

  assign outclk_o = outclk_q;
  assign stb_o    = stb_q;
  assign align_o  = (state_q == ALIGN);

endmodule

// File: rtl/hps_clkgen_multi.sv
// Multi-channel programmable clock generator: config handshake, resync fan-out,
// lock counter, and NUM_CH independent divided-clock channels.
module hps_clkgen_multi
  import hps_clkgen_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  CNT_W      = CFG_CNT_W,
  parameter int  LOCK_DELAY = 8,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_en,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic              resync,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outclk_stb,
  output logic              locked
);

  localparam int              LOCK_W    = $clog2(LOCK_DELAY + 1);
  localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCK_DELAY);
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
  localparam logic [CH_W:0]   NUM_CH_L  = (CH_W + 1)'(NUM_CH);

  logic              cfg_ready_q;
  logic              wr_pend_q;
  logic [CH_W-1:0]   wr_ch_q;
  cfg_t              wr_cfg_q;
  logic              resync_q;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [NUM_CH-1:0] align;
  logic              accept;
  logic              in_range;

  assign accept   = cfg_valid && cfg_ready_q;
  assign in_range = ({1'b0, cfg_ch} < NUM_CH_L);

  // Writes and resync are captured here and applied to the channels one cycle later,
  // so a coincident write and resync land on the same edge.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      cfg_ready_q <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_ch_q     <= '0;
      wr_cfg_q    <= CFG_RST;
      resync_q    <= 1'b0;
      lock_cnt_q  <= LOCK_INIT;
    end else begin
      cfg_ready_q <= !accept;
      wr_pend_q   <= accept && in_range;
      if (accept) begin
        wr_ch_q  <= cfg_ch;
        wr_cfg_q <= clamp_cfg(cfg_en, cfg_div, cfg_high, cfg_phase);
      end
      resync_q    <= resync;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (wr_pend_q || resync_q) begin
      lock_cnt_d = LOCK_INIT;
    end else if (!(|align) && (lock_cnt_q != '0)) begin
      lock_cnt_d = lock_cnt_q - LOCK_ONE;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hps_clkgen_ch u_ch (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .load_i     (wr_pend_q && (wr_ch_q == CH_W'(i))),
      .load_cfg_i (wr_cfg_q),
      .resync_i   (resync_q),
      .outclk_o   (outclk[i]),
      .stb_o      (outclk_stb[i]),
      .align_o    (align[i])
    );
  end

  assign cfg_ready = cfg_ready_q;
  assign locked    = (lock_cnt_q == '0);

endmodule

// File: tb/tb_hps_clkgen_multi.sv
// Directed bench for hps_clkgen_multi; five channels so that channel index 7 is out of range.
module tb_hps_clkgen_multi;

  localparam int NUM_CH     = 5;
  localparam int CNT_W      = 16;
  localparam int LOCK_DELAY = 8;
  localparam int CH_W       = 3;

  logic              refclk = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic              cfg_en;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_high;
  logic [CNT_W-1:0]  cfg_phase;
  logic              resync;
  logic [NUM_CH-1:0] outclk;
  logic [NUM_CH-1:0] outclk_stb;
  logic              locked;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int en_m [NUM_CH];
  int st_m [NUM_CH];
  int dv_m [NUM_CH];
  int hi_m [NUM_CH];
  int ph_m [NUM_CH];
  logic [4:0] pat;

  always #5 refclk = ~refclk;

  hps_clkgen_multi #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .LOCK_DELAY (LOCK_DELAY)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_en     (cfg_en),
    .cfg_div    (cfg_div),
    .cfg_high   (cfg_high),
    .cfg_phase  (cfg_phase),
    .resync     (resync),
    .outclk     (outclk),
    .outclk_stb (outclk_stb),
    .locked     (locked)
  );

  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, cyc);
    end
  endtask

  // A running channel started its first high cycle at st_m and repeats every dv_m cycles.
  function automatic logic [NUM_CH-1:0] exp_vec(input bit want_stb);
    logic [NUM_CH-1:0] v;
    int p;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en_m[i] != 0 && cyc >= st_m[i]) begin
        p    = (cyc - st_m[i]) % dv_m[i];
        v[i] = want_stb ? (p == 0) : (p < hi_m[i]);
      end
    end
    return v;
  endfunction

  task automatic chk_out();
    chk("outclk", 32'(outclk), 32'(exp_vec(1'b0)));
    chk("outclk_stb", 32'(outclk_stb), 32'(exp_vec(1'b1)));
  endtask

  task automatic rs_model();
    for (int i = 0; i < NUM_CH; i++)
      if (en_m[i] != 0) st_m[i] = cyc + 2 + ph_m[i];
  endtask

  task automatic pulse_rs();
    resync = 1'b1;
    step();
    resync = 1'b0;
    rs_model();
  endtask

  // Issues one accepted write; xdiv/xhigh are the hand-clamped values the channel should use.
  task automatic wr(input int ch, input bit en, input int div, input int high, input int phase,
                    input int xdiv, input int xhigh, input bit with_rs);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_en    = en;
    cfg_div   = CNT_W'(div);
    cfg_high  = CNT_W'(high);
    cfg_phase = CNT_W'(phase);
    resync    = with_rs;
    step();
    cfg_valid = 1'b0;
    resync    = 1'b0;
    chk("cfg_ready_apply", 32'(cfg_ready), 32'(0));
    if (ch < NUM_CH) begin
      en_m[ch] = int'(en);
      dv_m[ch] = xdiv;
      hi_m[ch] = xhigh;
      ph_m[ch] = phase;
      st_m[ch] = cyc + 2 + phase;
    end
    if (with_rs) rs_model();
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_en    = 1'b0;
    cfg_div   = '0;
    cfg_high  = '0;
    cfg_phase = '0;
    resync    = 1'b0;
    pat       = 5'b11000;
    for (int i = 0; i < NUM_CH; i++) begin
      en_m[i] = 0; st_m[i] = 0; dv_m[i] = 2; hi_m[i] = 1; ph_m[i] = 0;
    end

    step(); step(); step();
    chk("rst_outclk", 32'(outclk), 32'(0));
    chk("rst_stb", 32'(outclk_stb), 32'(0));
    chk("rst_locked", 32'(locked), 32'(0));
    chk("rst_ready", 32'(cfg_ready), 32'(0));
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_out();
      chk("idle_ready", 32'(cfg_ready), 32'(1));
      chk("idle_locked", 32'(locked), 32'(k >= 8));
    end

    // ch0 div=5 high=2 phase=0: ALIGN at T+1, first stb at T+2, relock at T+10.
    wr(0, 1'b1, 5, 2, 0, 5, 2, 1'b0);
    chk("wr0_locked_T", 32'(locked), 32'(1));
    for (int c = 1; c <= 11; c++) begin
      step();
      chk_out();
      chk("wr0_locked", 32'(locked), 32'(c >= 10));
      if (c == 1) chk("ready_after_apply", 32'(cfg_ready), 32'(1));
      if (c >= 2) chk("ch0_pattern", 32'(outclk[0]), 32'(pat[4 - ((c - 2) % 5)]));
    end

    wr(0, 1'b0, 5, 2, 0, 5, 2, 1'b0);
    step();
    chk_out();

    // Back-to-back: valid held high, accepted every other edge.
    chk("b2b_ready0", 32'(cfg_ready), 32'(1));
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_en = 1'b1;
    cfg_div = 16'd4; cfg_high = 16'd2; cfg_phase = 16'd3;
    step();
    chk("b2b_ready1", 32'(cfg_ready), 32'(0));
    en_m[1] = 1; dv_m[1] = 4; hi_m[1] = 2; ph_m[1] = 3; st_m[1] = cyc + 5;
    cfg_ch = 3'd2; cfg_phase = 16'd0;
    step();
    chk("b2b_ready2", 32'(cfg_ready), 32'(1));
    step();
    chk("b2b_ready3", 32'(cfg_ready), 32'(0));
    en_m[2] = 1; dv_m[2] = 4; hi_m[2] = 2; ph_m[2] = 0; st_m[2] = cyc + 2;
    cfg_valid = 1'b0;
    step();
    chk("b2b_ready4", 32'(cfg_ready), 32'(1));
    chk_out();

    // After resync ch2 rises at C+2, ch1 three cycles later at C+5.
    pulse_rs();
    for (int j = 1; j <= 13; j++) begin
      step();
      chk_out();
      chk("rs_locked", 32'(locked), 32'(j >= 13));
      if (j == 2) chk("ch2_first_stb", 32'(outclk_stb[2]), 32'(1));
      if (j == 5) chk("ch1_first_stb", 32'(outclk_stb[1]), 32'(1));
    end

    // Clamps: div=1 high=0 -> 2/1; div=6 high=9 -> 6/5, restarting a running channel.
    wr(3, 1'b1, 1, 0, 0, 2, 1, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      step();
      chk_out();
      chk("clamp1_locked", 32'(locked), 32'(0));
    end
    wr(3, 1'b1, 6, 9, 0, 6, 5, 1'b0);
    for (int j = 1; j <= 13; j++) begin
      step();
      chk_out();
      chk("clamp2_locked", 32'(locked), 32'(j >= 10));
    end

    wr(7, 1'b1, 3, 1, 0, 3, 1, 1'b0);
    for (int j = 1; j <= 10; j++) begin
      step();
      chk_out();
      chk("oor_locked", 32'(locked), 32'(1));
    end

    // Write ch0 together with resync: all enabled channels realign on the same edge.
    wr(0, 1'b1, 3, 1, 2, 3, 1, 1'b1);
    for (int j = 1; j <= 14; j++) begin
      step();
      chk_out();
      chk("coinc_locked", 32'(locked), 32'(j >= 13));
    end

    step(); step();
    rst_n = 1'b0;
    step();
    for (int i = 0; i < NUM_CH; i++) en_m[i] = 0;
    chk("midrst_outclk", 32'(outclk), 32'(0));
    chk("midrst_stb", 32'(outclk_stb), 32'(0));
    chk("midrst_locked", 32'(locked), 32'(0));
    chk("midrst_ready", 32'(cfg_ready), 32'(0));
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_out();
      chk("post_ready", 32'(cfg_ready), 32'(1));
      chk("post_locked", 32'(locked), 32'(k >= 8));
    end
    pulse_rs();
    for (int j = 1; j <= 10; j++) begin
      step();
      chk_out();
      chk("post_rs_locked", 32'(locked), 32'(j >= 9));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
